// File: rtl/ipbb_pipe_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ipbb_pipe_sched_pkg
//  Description : Shared widths, helper functions and the in-flight tag entry
//                for the round-robin pipe scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ipbb_pipe_sched_pkg;

   // Widest tag ever needed (NREQ is capped at 16); the entry type is sized to
   // this so one typedef serves every NREQ instance.
   localparam int MAX_TAG_W = 4;

   // Bits needed to name a requester.
   function automatic int tag_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Bits needed to count 0..CRED outstanding transactions.
   function automatic int cnt_w(input int cred);
      return $clog2(cred + 1);
   endfunction

   // One slot of the tag shift register that shadows the external data pipe.
   typedef struct packed {
      logic                 vld;
      logic [MAX_TAG_W-1:0] tag;
   } inflight_t;

endpackage
`default_nettype wire

// File: rtl/ipbb_pipe_rr_sched_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ipbb_rr_arb
//  Description : NREQ-way round-robin arbiter. Search starts one past the
//                pointer and wraps; the pointer moves to the winner only when
//                the grant is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipbb_rr_arb
   import ipbb_pipe_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          elig,
   input  logic                     accept,
   output logic [NREQ-1:0]          grant,
   output logic [tag_w(NREQ)-1:0]   grant_idx
);

   localparam int PTR_W = tag_w(NREQ);

   logic [PTR_W-1:0] r_ptr;

   // Pick the first eligible requester after the pointer, wrapping modulo NREQ.
   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(r_ptr) + k) % NREQ;
         if (!found && elig[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            grant_idx             = idx[PTR_W-1:0];
            found                 = 1'b1;
         end
      end
   end

   // Pointer starts at NREQ-1 so requester 0 has first priority after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= PTR_W'(NREQ - 1);
      end else if (accept) begin
         r_ptr <= grant_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ipbb_pipe_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ipbb_pipe_rr_sched
//  Description : Shares one fixed-latency external delay pipe among NREQ
//                requesters. Grants round-robin, shadows the pipe with a tag
//                shift register and steers each returning word back to its
//                owner. Per-requester credits bound outstanding work.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipbb_pipe_rr_sched
   import ipbb_pipe_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 64,
   parameter int LAT  = 2,
   parameter int CRED = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sched_en,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*W-1:0]   req_data,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     cred_return,
   output logic [W-1:0]        pipe_din,
   input  logic [W-1:0]        pipe_dout,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [W-1:0]        rsp_data,
   output logic                idle
);

   localparam int TAG_W = tag_w(NREQ);
   localparam int CNT_W = cnt_w(CRED);
   localparam logic [CNT_W-1:0] c_cred_max = CNT_W'(CRED);

   logic [CNT_W-1:0] r_cnt [NREQ];
   inflight_t        r_stage [LAT+1];
   logic [NREQ-1:0]  w_elig;
   logic [NREQ-1:0]  w_grant;
   logic [NREQ-1:0]  w_take;
   logic [NREQ-1:0]  w_inc;
   logic [NREQ-1:0]  w_dec;
   logic [TAG_W-1:0] w_grant_idx;
   logic             w_fire;
   logic [NREQ-1:0]  w_rsp_vec;
   logic             w_busy;

   // Per-requester eligibility and credit up/down events. A return at zero is
   // dropped so the counter cannot underflow.
   for (genvar i = 0; i < NREQ; i++) begin : g_elig
      assign w_elig[i] = req_valid[i] && (r_cnt[i] < c_cred_max) && sched_en;
      assign w_take[i] = req_valid[i] && w_grant[i];
      assign w_inc[i]  = w_take[i];
      assign w_dec[i]  = cred_return[i] && (r_cnt[i] != '0);
   end

   assign w_fire    = |w_take;
   assign req_ready = w_grant;

   ipbb_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .elig      (w_elig),
      .accept    (w_fire),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   // Credit counters: grant and return in one cycle cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (!w_inc[i] && w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   // Register the granted word onto the pipe input; hold it otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_din <= '0;
      end else if (w_fire) begin
         pipe_din <= req_data[w_grant_idx*W +: W];
      end
   end

   // Tag shift register: stage 0 lines up with pipe_din, stage LAT with
   // pipe_dout. It carries the only valid information the pipe has.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= LAT; k++) r_stage[k] <= '0;
      end else begin
         r_stage[0] <= {w_fire, MAX_TAG_W'(w_grant_idx)};
         for (int k = 1; k <= LAT; k++) r_stage[k] <= r_stage[k-1];
      end
   end

   // Decode the emerging tag into a one-hot response strobe.
   always_comb begin
      w_rsp_vec = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_rsp_vec[i] = r_stage[LAT].vld && (r_stage[LAT].tag == MAX_TAG_W'(i));
      end
   end

   // Response register: strobe lasts one cycle, data is captured alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= w_rsp_vec;
         if (r_stage[LAT].vld) begin
            rsp_data <= pipe_dout;
         end
      end
   end

   // Busy while anything is in flight, being delivered or still holding credit.
   always_comb begin
      w_busy = |rsp_valid;
      for (int k = 0; k <= LAT; k++) w_busy = w_busy | r_stage[k].vld;
      for (int i = 0; i < NREQ; i++) w_busy = w_busy | (r_cnt[i] != '0);
   end

   assign idle = !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ipbb_pipe_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipbb_pipe_rr_sched
//  Description : Directed, self-checking bench for ipbb_pipe_rr_sched with a
//                two-stage external pipe model and a fixed-latency response
//                model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ipbb_pipe_rr_sched;

   localparam int NREQ = 4;
   localparam int W    = 64;
   localparam int LAT  = 2;
   localparam int CRED = 4;

   logic              clk         = 1'b0;
   logic              rst_n       = 1'b0;
   logic              sched_en    = 1'b0;
   logic [NREQ-1:0]   req_valid   = '0;
   logic [NREQ*W-1:0] req_data    = '0;
   logic [NREQ-1:0]   cred_return = '0;
   logic [NREQ-1:0]   req_ready;
   logic [W-1:0]      pipe_din;
   logic [W-1:0]      pipe_dout;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              idle;

   int                n_pass    = 0;
   int                n_total   = 0;
   logic              mon_en    = 1'b0;
   logic              hold_data = 1'b0;
   logic              auto_ret  = 1'b0;
   logic [W-1:0]      data_base = '0;
   logic [W-1:0]      pd1;

   // Expected grant for the current cycle and the response it must produce
   logic [NREQ-1:0]   m_grant = '0;
   logic [NREQ-1:0]   m_v [LAT+2];
   logic [W-1:0]      m_d [LAT+2];

   always #5 clk = ~clk;

   ipbb_pipe_rr_sched #(
      .NREQ (NREQ),
      .W    (W),
      .LAT  (LAT),
      .CRED (CRED)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sched_en    (sched_en),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .cred_return (cred_return),
      .pipe_din    (pipe_din),
      .pipe_dout   (pipe_dout),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .idle        (idle)
   );

   // External delay pipe (LAT = 2 stages, no reset, no valid)
   always @(posedge clk) begin
      pd1       <= pipe_din;
      pipe_dout <= pd1;
   end

   function automatic logic [W-1:0] sel_data(input logic [NREQ-1:0] g);
      logic [W-1:0] d;
      d = '0;
      for (int i = 0; i < NREQ; i++) if (g[i]) d = req_data[i*W +: W];
      return d;
   endfunction

   // Response model: a granted word appears LAT+2 cycles after its grant
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT+2; k++) begin
            m_v[k] <= '0;
            m_d[k] <= '0;
         end
      end else begin
         m_v[0] <= m_grant;
         m_d[0] <= sel_data(m_grant);
         for (int k = 1; k < LAT+2; k++) begin
            m_v[k] <= m_v[k-1];
            m_d[k] <= m_d[k-1];
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Every cycle: compare the response strobe/data against the model
   always @(negedge clk) begin
      if (mon_en) begin
         check("rsp_valid", {{(W-NREQ){1'b0}}, rsp_valid}, {{(W-NREQ){1'b0}}, m_v[LAT+1]});
         if (m_v[LAT+1] != '0) check("rsp_data", rsp_data, m_d[LAT+1]);
      end
   end

   // One clock cycle of stimulus plus the grant comparison for that cycle
   task automatic step(input logic en, input logic [3:0] v, input logic [3:0] cr,
                       input logic [3:0] eg);
      @(posedge clk);
      #1;
      sched_en    = en;
      req_valid   = v;
      cred_return = auto_ret ? m_v[LAT+1] : cr;
      m_grant     = eg;
      if (!hold_data) data_base = data_base + 64'h0001_0203_0405_0607;
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = data_base ^ (64'(i) << 56);
      @(negedge clk);
      check("req_ready", {60'd0, req_ready}, {60'd0, eg});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      req_valid   = '0;
      cred_return = '0;
      sched_en    = 1'b0;
      m_grant     = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic       en;
      logic [3:0] v;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Arbitration sequence from reset (pointer = 3, all credits free)
      tbl[0]  = '{1'b1, 4'b0000, 4'b0000};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[2]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[3]  = '{1'b0, 4'b1111, 4'b0000};
      tbl[4]  = '{1'b1, 4'b1001, 4'b1000};
      tbl[5]  = '{1'b1, 4'b1001, 4'b0001};
      tbl[6]  = '{1'b1, 4'b0100, 4'b0100};
      tbl[7]  = '{1'b1, 4'b0011, 4'b0001};
      tbl[8]  = '{1'b1, 4'b0011, 4'b0010};
      tbl[9]  = '{1'b1, 4'b0001, 4'b0001};
      tbl[10] = '{1'b1, 4'b0001, 4'b0000};
      tbl[11] = '{1'b1, 4'b0000, 4'b0000};

      do_reset();
      mon_en = 1'b1;
      check("reset_idle", {63'd0, idle}, 64'd1);
      check("reset_pipe_din", pipe_din, 64'd0);
      check("reset_rsp_data", rsp_data, 64'd0);

      for (int k = 0; k < 12; k++) step(tbl[k].en, tbl[k].v, 4'b0000, tbl[k].exp);

      // Single request: grant, pipe_din next cycle, response 4 cycles later
      do_reset();
      hold_data = 1'b1;
      data_base = 64'hA5;
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b0001, 4'b0000, 4'b0001);
      check("single_idle_grant_cycle", {63'd0, idle}, 64'd1);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("single_pipe_din", pipe_din, 64'hA5);
      check("single_idle_busy", {63'd0, idle}, 64'd0);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("single_rsp_valid", {60'd0, rsp_valid}, 64'd1);
      check("single_rsp_data", rsp_data, 64'hA5);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("single_idle_credit_held", {63'd0, idle}, 64'd0);
      step(1'b1, 4'b0000, 4'b0001, 4'b0000);
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("single_idle_after_return", {63'd0, idle}, 64'd1);
      hold_data = 1'b0;

      // Fairness: all valid, credits returned as responses arrive
      do_reset();
      auto_ret = 1'b1;
      for (int k = 0; k < 12; k++) step(1'b1, 4'b1111, 4'b0000, 4'(1 << (k % 4)));
      for (int k = 0; k < 6; k++) step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("fair_idle_drained", {63'd0, idle}, 64'd1);
      auto_ret = 1'b0;

      // Credit exhaustion and counter corner cases on requester 2
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0100, 4'b0000, 4'b0100);
      step(1'b1, 4'b0100, 4'b0000, 4'b0000);
      step(1'b1, 4'b0100, 4'b0000, 4'b0000);
      step(1'b1, 4'b0100, 4'b0100, 4'b0000);   // return at cnt=4: not yet eligible
      step(1'b1, 4'b0100, 4'b0000, 4'b0100);   // exactly one further grant
      step(1'b1, 4'b0100, 4'b0000, 4'b0000);
      step(1'b1, 4'b0000, 4'b0100, 4'b0000);   // cnt 4 -> 3
      step(1'b1, 4'b0100, 4'b0100, 4'b0100);   // grant + return at 3 -> stays 3
      step(1'b1, 4'b0100, 4'b0000, 4'b0100);   // 3 -> 4
      step(1'b1, 4'b0100, 4'b0000, 4'b0000);
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0000, 4'b0100, 4'b0000);
      step(1'b1, 4'b0000, 4'b0100, 4'b0000);   // return at cnt=0 is ignored
      step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("cred_idle_zero", {63'd0, idle}, 64'd1);
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0100, 4'b0000, 4'b0100);
      step(1'b1, 4'b0100, 4'b0000, 4'b0000);

      // sched_en drop with three words in flight
      do_reset();
      step(1'b1, 4'b1111, 4'b0000, 4'b0001);
      step(1'b1, 4'b1111, 4'b0000, 4'b0010);
      step(1'b1, 4'b1111, 4'b0000, 4'b0100);
      for (int k = 0; k < 6; k++) step(1'b0, 4'b1111, 4'b0000, 4'b0000);
      check("en_idle_credits_held", {63'd0, idle}, 64'd0);
      step(1'b0, 4'b0000, 4'b0111, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000, 4'b0000);
      check("en_idle_after_return", {63'd0, idle}, 64'd1);

      // Reset with two words in flight: nothing emerges, pointer restarts
      do_reset();
      step(1'b1, 4'b0011, 4'b0000, 4'b0001);
      step(1'b1, 4'b0011, 4'b0000, 4'b0010);
      do_reset();
      check("rst_idle", {63'd0, idle}, 64'd1);
      for (int k = 0; k < 5; k++) step(1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("rst_idle_after_drain", {63'd0, idle}, 64'd1);
      step(1'b1, 4'b1111, 4'b0000, 4'b0001);
      for (int k = 0; k < 5; k++) step(1'b1, 4'b0000, 4'b0000, 4'b0000);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
